sha_hash_ctrl: RTL and testbench
================================

// Module: sha_hash_ctrl
// PURPOSE
// - Sequencer for the SHA-256/SHA-512 hash core. Accepts a start command with a mode, then handshakes message blocks in.
// - For each block: loads the IV on the first block, loads the working vars A..H, and steps the round counter over 64 or 80 rounds.
// - Commits H += A..H after the rounds of each block.
// - On the last block, pulses sel_res256/sel_res512 so the result register captures H0..H7 + A..H. Then flags done.
// PARAMETERS
// ROUNDS_256   64   rounds per block, SHA-256 mode
// ROUNDS_512   80   rounds per block, SHA-512 mode
// IDX_W        7    width of round index (must hold ROUNDS_512-1)
// PORTS
// clk         in   1      clock, all logic on rising edge
// rst         in   1      reset, synchronous, active-high
// start       in   1      begin a new hash; sampled only in IDLE
// mode        in   1      0 = SHA-256, 1 = SHA-512; latched with start
// blk_valid   in   1      message block available
// blk_last    in   1      qualifies blk_valid: final block of message
// blk_ready   out  1      controller accepts block (transfer = blk_valid & blk_ready)
// ld_msg      out  1      1-cycle pulse: message schedule loads accepted block
// ld_iv       out  1      1-cycle pulse: H0..H7 <= initial hash values (first block only)
// ld_work     out  1      1-cycle pulse: A..H <= H0..H7
// rnd_en      out  1      compression round active this cycle
// rnd_idx     out  IDX_W  current round t (K/W index)
// upd_h       out  1      1-cycle pulse: H_i <= H_i + working var
// sel_res256  out  1      result-register load enable, SHA-256
// sel_res512  out  1      result-register load enable, SHA-512
// busy        out  1      high in every state except IDLE
// done        out  1      1-cycle pulse: result register valid
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE; all outputs 0; rnd_idx=0; mode_q=0; first_q=0; last_q=0.
//   - Reset mid-operation aborts the hash immediately. No sel_res* or done is issued.
// - FSM states: IDLE, WAIT_BLK, INIT, ROUND, UPDATE, DONE. All outputs are decoded from registered state/counters.
// - IDLE: blk_ready=0, busy=0. On start: mode_q<=mode, first_q<=1, next state WAIT_BLK. Otherwise stay.
// - WAIT_BLK: blk_ready=1. On blk_valid:
//   - ld_msg=1 the same cycle; last_q<=blk_last; next state INIT.
//   - Without blk_valid, wait indefinitely.
// - INIT (1 cycle): ld_iv=first_q; ld_work=1; rnd_idx<=0; next state ROUND.
// - ROUND: rnd_en=1, rnd_idx=t.
//   - t increments each cycle.
//   - At t==NR-1 (NR=ROUNDS_256 if mode_q=0, else ROUNDS_512): rnd_idx<=0, next state UPDATE.
// - UPDATE (1 cycle): upd_h=1; first_q<=0.
//   - If last_q: sel_res256=~mode_q and sel_res512=mode_q in this same cycle. The result register sums pre-update H with final A..H. Next state DONE.
//   - Else next state WAIT_BLK.
// - DONE (1 cycle): done=1; next state IDLE. busy=1 in DONE and drops in IDLE.
// - start while busy is ignored, and is not queued. mode changes while busy are ignored.
// - blk_valid outside WAIT_BLK is ignored.
// - sel_res256 and sel_res512 are mutually exclusive and never both high.
// - At most one of ld_msg/ld_work/rnd_en/upd_h is high per cycle.
// - Latency: per block = 1 accept + 1 INIT + NR rounds + 1 UPDATE.
//   - Single-block SHA-256 with blk_valid held high: start@c0, accept@c1, INIT@c2, rounds c3..c66, UPDATE/sel_res256@c67, done@c68.
// - Counter never wraps: terminates at NR-1. rnd_idx is held at 0 outside ROUND.
// STRUCTURE
// - Shared package sha_ctrl_pkg holds:
//   - state enum
//   - MODE_SHA256=1'b0, MODE_SHA512=1'b1
//   - ROUNDS_256/ROUNDS_512 constants, IDX_W
// - One sub-module, sha_round_cnt: clear/enable counter with terminal-count flag at programmable limit NR-1. FSM stays in this module.
// TESTING
// - Single-block SHA-256, blk_valid high: start@c0 -> rnd_en c3..c66 with rnd_idx 0..63, sel_res256@c67 only, done@c68, busy low c69.
// - Single-block SHA-512: rnd_idx 0..79 -> sel_res512 only, in cycle 80 rounds after INIT; sel_res256 stays 0.
// - Two-block SHA-256 (blk_last=0 then 1): ld_iv on block 1 only; upd_h twice; sel_res256 only after block 2; done once.
// - Stalled source: blk_valid low 10 cycles in WAIT_BLK -> blk_ready stays 1, no ld_msg; accept on first valid cycle.
// - start pulsed during ROUND and mode toggled -> ignored; rounds and sel_res follow the originally latched mode.
// - rst asserted at rnd_idx=30 -> next cycle IDLE, all outputs 0, no sel_res*/done. A fresh start then completes normally.

Source files
------------

// File: rtl/sha_ctrl_pkg.sv
// Shared definitions for the SHA-256/SHA-512 hash sequencer: FSM state
// encoding, mode encoding, per-mode round counts and the round index width.
package sha_ctrl_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;
  localparam int IDX_W      = 7;   // holds ROUNDS_512-1

  localparam logic MODE_SHA256 = 1'b0;
  localparam logic MODE_SHA512 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  // Final round index (NR-1) for the latched mode.
  function automatic logic [IDX_W-1:0] last_idx(input logic mode);
    return (mode == MODE_SHA512) ? IDX_W'(ROUNDS_512 - 1) : IDX_W'(ROUNDS_256 - 1);
  endfunction

endpackage

// File: rtl/sha_round_cnt.sv
// Round counter for the hash sequencer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force index to 0
//   en        - advance one round
//   limit     - terminal index (NR-1)
//   idx       - current round index
//   tc        - idx has reached limit
// On an enabled terminal cycle the index returns to 0, so it never wraps
// past the limit and sits at 0 whenever rounds are not running.
module sha_round_cnt
  import sha_ctrl_pkg::*;
#(
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] idx,
  output logic         tc
);

  assign tc = (idx == limit);

  always_ff @(posedge clk) begin
    if (rst || clr)  idx <= '0;
    else if (en)     idx <= tc ? '0 : idx + W'(1);
  end

endmodule

// File: rtl/sha_hash_ctrl.sv
// Sequencer for the SHA-256/SHA-512 compression core.
// Accepts a start command with a mode, handshakes message blocks in, and for
// each block loads IV (first block only) and working vars, runs NR rounds,
// then commits H += A..H. On the last block the result register is loaded
// in the UPDATE cycle, and done pulses one cycle later.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   start, mode            - new hash request and SHA-256(0)/SHA-512(1)
//   blk_valid, blk_last    - block source handshake; blk_ready in return
//   ld_msg, ld_iv, ld_work - datapath load strobes
//   rnd_en, rnd_idx        - round active and round index t
//   upd_h                  - H_i += working var
//   sel_res256/512         - result register load enables
//   busy, done             - status
module sha_hash_ctrl
  import sha_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             blk_valid,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic             ld_msg,
  output logic             ld_iv,
  output logic             ld_work,
  output logic             rnd_en,
  output logic [IDX_W-1:0] rnd_idx,
  output logic             upd_h,
  output logic             sel_res256,
  output logic             sel_res512,
  output logic             busy,
  output logic             done
);

  state_t state, state_nxt;
  logic   mode_q, first_q, last_q;
  logic   cnt_clr, cnt_tc;

  sha_round_cnt #(.W(IDX_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (rnd_en),
    .limit (last_idx(mode_q)),
    .idx   (rnd_idx),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mode_q  <= MODE_SHA256;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // mode/first are only captured from IDLE so requests while busy are dropped
      if (state == S_IDLE && start) begin
        mode_q  <= mode;
        first_q <= 1'b1;
      end
      if (state == S_WAIT_BLK && blk_valid) last_q  <= blk_last;
      if (state == S_UPDATE)                first_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    blk_ready  = 1'b0;
    ld_msg     = 1'b0;
    ld_iv      = 1'b0;
    ld_work    = 1'b0;
    rnd_en     = 1'b0;
    upd_h      = 1'b0;
    sel_res256 = 1'b0;
    sel_res512 = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: if (start) state_nxt = S_WAIT_BLK;
      S_WAIT_BLK: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          ld_msg    = 1'b1;
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        ld_iv     = first_q;
        ld_work   = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        rnd_en = 1'b1;
        if (cnt_tc) state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        upd_h = 1'b1;
        // result register adds pre-update H to final A..H in this same cycle
        if (last_q) begin
          sel_res256 = (mode_q == MODE_SHA256);
          sel_res512 = (mode_q == MODE_SHA512);
          state_nxt  = S_DONE;
        end else begin
          state_nxt  = S_WAIT_BLK;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha_hash_ctrl.sv
// Directed bench for sha_hash_ctrl: a cycle table of {inputs, expected
// strobes} records, plus hand-written reset and bounded-completion sequences.
module tb_sha_hash_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, mode, blk_valid, blk_last;
  logic       blk_ready, ld_msg, ld_iv, ld_work, rnd_en, upd_h;
  logic       sel_res256, sel_res512, busy, done;
  logic [6:0] rnd_idx;

  int n_chk  = 0;
  int n_fail = 0;

  sha_hash_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
    .ld_msg(ld_msg), .ld_iv(ld_iv), .ld_work(ld_work), .rnd_en(rnd_en),
    .rnd_idx(rnd_idx), .upd_h(upd_h), .sel_res256(sel_res256),
    .sel_res512(sel_res512), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // output flag vector: {busy, ready, ld_msg, ld_iv, ld_work, rnd_en, upd_h, s256, s512, done}
  localparam logic [9:0] F_BUSY = 10'h200, F_RDY  = 10'h100, F_MSG = 10'h080,
                         F_IV   = 10'h040, F_WORK = 10'h020, F_RND = 10'h010,
                         F_UPD  = 10'h008, F_S256 = 10'h004, F_S512 = 10'h002,
                         F_DONE = 10'h001;
  localparam logic [9:0] E_IDLE  = 10'h000;
  localparam logic [9:0] E_WAIT  = F_BUSY | F_RDY;
  localparam logic [9:0] E_ACC   = F_BUSY | F_RDY | F_MSG;
  localparam logic [9:0] E_INIT1 = F_BUSY | F_IV | F_WORK;
  localparam logic [9:0] E_INIT  = F_BUSY | F_WORK;
  localparam logic [9:0] E_RND   = F_BUSY | F_RND;
  localparam logic [9:0] E_UPD   = F_BUSY | F_UPD;
  localparam logic [9:0] E_DONE  = F_BUSY | F_DONE;

  typedef struct {
    bit         rst, start, mode, valid, last;
    int         reps;   // cycles this record is applied
    int         idx0;   // expected rnd_idx on first rep when rounds run
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, s, m, v, l, input int reps, idx0, input logic [9:0] e);
    vec_t x;
    x.rst = r; x.start = s; x.mode = m; x.valid = v; x.last = l;
    x.reps = reps; x.idx0 = idx0; x.exp = e;
    tbl.push_back(x);
  endtask

  function automatic logic [9:0] flags();
    return {busy, blk_ready, ld_msg, ld_iv, ld_work, rnd_en, upd_h, sel_res256, sel_res512, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int done_cyc, n256, n512, nupd;

    // --- single-block SHA-256, blk_valid held high throughout
    add(0,1,0,1,1, 1,0, E_IDLE);          // c0 start
    add(0,0,0,1,1, 1,0, E_ACC);           // c1
    add(0,0,0,1,1, 1,0, E_INIT1);         // c2 (valid ignored)
    add(0,0,0,1,1,64,0, E_RND);           // c3..c66
    add(0,0,0,1,1, 1,0, E_UPD | F_S256);  // c67
    add(0,0,0,1,1, 1,0, E_DONE);          // c68
    add(0,0,0,1,1, 1,0, E_IDLE);          // c69
    // --- single-block SHA-512
    add(0,1,1,1,1, 1,0, E_IDLE);
    add(0,0,0,1,1, 1,0, E_ACC);
    add(0,0,0,0,0, 1,0, E_INIT1);
    add(0,0,0,0,0,80,0, E_RND);
    add(0,0,0,0,0, 1,0, E_UPD | F_S512);
    add(0,0,0,0,0, 1,0, E_DONE);
    add(0,0,0,0,0, 1,0, E_IDLE);
    // --- two-block SHA-256
    add(0,1,0,0,0, 1,0, E_IDLE);
    add(0,0,0,1,0, 1,0, E_ACC);
    add(0,0,0,0,0, 1,0, E_INIT1);
    add(0,0,0,0,0,64,0, E_RND);
    add(0,0,0,0,0, 1,0, E_UPD);
    add(0,0,0,1,1, 1,0, E_ACC);
    add(0,0,0,0,0, 1,0, E_INIT);          // no ld_iv on block 2
    add(0,0,0,0,0,64,0, E_RND);
    add(0,0,0,0,0, 1,0, E_UPD | F_S256);
    add(0,0,0,0,0, 1,0, E_DONE);
    add(0,0,0,0,0, 2,0, E_IDLE);
    // --- stalled source, then start/mode toggled during SHA-512 rounds
    add(0,1,1,0,0, 1,0, E_IDLE);
    add(0,0,1,0,0,10,0, E_WAIT);
    add(0,0,1,1,1, 1,0, E_ACC);
    add(0,0,1,0,0, 1,0, E_INIT1);
    add(0,1,0,0,0,80,0, E_RND);
    add(0,0,0,0,0, 1,0, E_UPD | F_S512);
    add(0,0,0,0,0, 1,0, E_DONE);
    add(0,0,0,0,0, 1,0, E_IDLE);
    // --- reset at rnd_idx=30, then fresh hash
    add(0,1,0,1,1, 1,0, E_IDLE);
    add(0,0,0,1,1, 1,0, E_ACC);
    add(0,0,0,0,0, 1,0, E_INIT1);
    add(0,0,0,0,0,30,0, E_RND);
    add(1,0,0,0,0, 1,30, E_RND);
    add(0,0,0,1,1, 3,0, E_IDLE);
    add(0,1,0,1,1, 1,0, E_IDLE);
    add(0,0,0,1,1, 1,0, E_ACC);
    add(0,0,0,0,0, 1,0, E_INIT1);
    add(0,0,0,0,0,64,0, E_RND);
    add(0,0,0,0,0, 1,0, E_UPD | F_S256);
    add(0,0,0,0,0, 1,0, E_DONE);
    add(0,0,0,0,0, 1,0, E_IDLE);

    // --- reset state
    rst = 1'b1; start = 1'b0; mode = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 32'(flags()), 32'(E_IDLE));
    chk("reset_idx", 32'(rnd_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // --- table
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        rst = tbl[r].rst; start = tbl[r].start; mode = tbl[r].mode;
        blk_valid = tbl[r].valid; blk_last = tbl[r].last;
        @(negedge clk);
        n_chk++;
        if ({flags(), rnd_idx} !== {tbl[r].exp, (tbl[r].exp[4] ? 7'(tbl[r].idx0 + k) : 7'd0)}) begin
          n_fail++;
          $display("FAIL row%0d rep%0d: flags=%b idx=%0d expected flags=%b idx=%0d",
                   r, k, flags(), rnd_idx, tbl[r].exp,
                   tbl[r].exp[4] ? tbl[r].idx0 + k : 0);
        end
        @(posedge clk); #1;
      end
    end
    rst = 1'b0; start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;

    // --- bounded completion run, SHA-512 single block: done expected at c84
    done_cyc = -1; n256 = 0; n512 = 0; nupd = 0;
    start = 1'b1; mode = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (sel_res256) n256++;
      if (sel_res512) n512++;
      if (upd_h)      nupd++;
      if (done)       done_cyc = c;
      @(posedge clk); #1;
      start = 1'b0; mode = 1'b0;
    end
    blk_valid = 1'b0;
    chk("run512_done_cycle", 32'(done_cyc), 32'd84);
    chk("run512_sel512_cnt", 32'(n512), 32'd1);
    chk("run512_sel256_cnt", 32'(n256), 32'd0);
    chk("run512_upd_cnt", 32'(nupd), 32'd1);
    @(negedge clk);
    chk("run512_idle_after", 32'(flags()), 32'(E_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
